reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//   Central reset controller for the flop banks of a design. Takes the raw
//   async reset, asserts all reset outputs immediately, and deasserts them
//   synchronously to clk. Deassertion is staged: one output at a time, in
//   index order, STAGE_DELAY cycles apart. Also services a software reset
//   request via a req/ack handshake. Each output drives sync-reset DFF banks.
// PARAMETERS
//   NUM_OUT      4  number of staged reset outputs (>=1)
//   SYNC_STAGES  2  reset-deassert synchronizer depth (>=2)
//   STAGE_DELAY  8  cycles between successive releases (>=1)
//   HOLD_CYCLES  4  cycles all outputs are held asserted on sw reset (>=1)
// PORTS
//   clk           in   1        clock
//   reset         in   1        reset, asynchronous, active-high
//   sw_rst_req_i  in   1        level software reset request
//   sw_rst_ack_o  out  1        1-cycle pulse: sw reset hold done
//   rst_o         out  NUM_OUT  active-high resets; bit 0 released first
//   all_done_o    out  1        1 when every rst_o bit is released
//   busy_o        out  1        1 in every state except RUN
// BEHAVIOUR
//   Reset (async, any time, incl. mid-sequence or mid-sw-hold):
//   - rst_o = all 1s, sw_rst_ack_o = 0, all_done_o = 0, busy_o = 1.
//   - Sync chain is set to all 1s, counter = 0, state = WAIT.
//   Synchronizer: SYNC_STAGES flops, preset by reset, shifting in 0.
//   - No output reacts to reset deassert except through this chain.
//   - Reset deassert has no combinational path to any output.
//   All outputs are registered; no glitches on rst_o.
//   FSM: WAIT -> RELEASE -> RUN -> SW_HOLD -> RELEASE ...
//   - WAIT: wait for the synchronized reset to drop, then go to RELEASE.
//   - RELEASE: counter counts STAGE_DELAY cycles per stage. At the end of
//     each stage, the next-lowest still-asserted bit is cleared. After bit
//     NUM_OUT-1 clears, go to RUN. On that same edge all_done_o becomes 1.
//   - Timing from reset: count posedges after reset falls, with the first
//     posedge sampling reset low = 1. rst_o[i] clears at posedge
//     SYNC_STAGES + (i+1)*STAGE_DELAY.
//   - RUN: outputs stable. If a posedge samples sw_rst_req_i=1, then on
//     that edge: rst_o = all 1s, all_done_o = 0, state = SW_HOLD.
//   - SW_HOLD: lasts HOLD_CYCLES cycles. On the edge HOLD_CYCLES after the
//     request edge, sw_rst_ack_o = 1 for exactly 1 cycle and state =
//     RELEASE. After that, rst_o[i] clears (i+1)*STAGE_DELAY edges later.
//   Handshake rules:
//   - sw_rst_req_i is sampled only in RUN. It is ignored in WAIT, RELEASE
//     and SW_HOLD, and no ack is given for it there.
//   - A request still high when RUN is reached is serviced.
//   - Requester must drop req on ack, or a second sw reset follows.
//   Counter is $clog2(STAGE_DELAY+HOLD_CYCLES)+1 bits wide and never wraps.
//   It is cleared on every state change and on every stage release.
//   rst_o bits are monotone within a sequence: a released bit never
//   re-asserts except on reset or on sw reset.
// TESTING
//   1. Power-on with defaults, reset low at posedge 1: rst_o clears 4'b1111
//      -> 1110@10, 1100@18, 1000@26, 0000@34. all_done_o=1@34, busy_o=0@34.
//   2. Reset pulse of 3ns between clk edges: rst_o=1111 immediately,
//      asynchronously. Full sequence restarts as in test 1.
//   3. In RUN, req=1 at edge E: rst_o=1111@E, ack pulse@E+4 only.
//      Release at E+12, E+20, E+28, E+36. req dropped on ack: no repeat.
//   4. req=1 held during the initial RELEASE phase: no ack and no effect
//      until the RUN edge. Serviced on the first RUN sampling edge.
//   5. Reset asserted during SW_HOLD and during mid-RELEASE: all outputs
//      return to their reset values at once. No ack is issued.
//   6. Params NUM_OUT=1, STAGE_DELAY=1, SYNC_STAGES=3: rst_o clears @4.
//      all_done_o=1@4.

Source files
------------

// File: rtl/reset_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : reset_sequencer
// Purpose  : Central reset controller. Asserts every reset output as soon as
//            the raw reset rises (asynchronously). Releases the outputs
//            synchronously to clk, one at a time in index order, STAGE_DELAY
//            cycles apart. Also services a level software reset request and
//            acknowledges it with a one-cycle pulse.
// Revision : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
    parameter int NUM_OUT     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STAGE_DELAY = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sw_rst_req_i,
    output logic               sw_rst_ack_o,
    output logic [NUM_OUT-1:0] rst_o,
    output logic               all_done_o,
    output logic               busy_o
);

    localparam int c_cnt_w = $clog2(STAGE_DELAY + HOLD_CYCLES) + 1;
    localparam logic [c_cnt_w-1:0] c_stage_last = c_cnt_w'(STAGE_DELAY - 1);
    localparam logic [c_cnt_w-1:0] c_hold_last  = c_cnt_w'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_WAIT    = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2,
        S_SW_HOLD = 2'd3
    } state_t;

    // The synchronizer has SYNC_STAGES-1 explicit flops; the state register
    // leaving WAIT acts as the final stage, so the release sequence starts on
    // the edge where the full SYNC_STAGES-deep chain would have dropped.
    logic [SYNC_STAGES-2:0] r_sync;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [NUM_OUT-1:0]   r_rst;
    logic [NUM_OUT-1:0]   w_rst_nxt;
    logic [NUM_OUT-1:0]   w_rst_shift;
    logic                 r_ack;
    logic                 w_ack_nxt;
    logic                 r_done;
    logic                 w_done_nxt;
    logic                 r_busy;
    logic                 w_busy_nxt;

    // Released bits are always the low ones, so releasing the next bit is a
    // left shift that brings in a zero at the bottom.
    assign w_rst_shift = r_rst << 1;

    // Reset-deassert synchronizer: preset by reset, shifts in zeros.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '1;
        end else begin
            r_sync <= r_sync << 1;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
            r_rst   <= '1;
            r_ack   <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rst   <= w_rst_nxt;
            r_ack   <= w_ack_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Next-state and next-output logic for the sequencing FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rst_nxt   = r_rst;
        w_ack_nxt   = 1'b0;
        w_done_nxt  = r_done;

        case (r_state)
            S_WAIT: begin
                if (!r_sync[SYNC_STAGES-2]) begin
                    w_state_nxt = S_RELEASE;
                    w_cnt_nxt   = '0;
                end
            end

            S_RELEASE: begin
                if (r_cnt == c_stage_last) begin
                    w_rst_nxt = w_rst_shift;
                    w_cnt_nxt = '0;
                    if (w_rst_shift == '0) begin
                        w_state_nxt = S_RUN;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            S_RUN: begin
                if (sw_rst_req_i) begin
                    w_state_nxt = S_SW_HOLD;
                    w_cnt_nxt   = '0;
                    w_rst_nxt   = '1;
                    w_done_nxt  = 1'b0;
                end
            end

            S_SW_HOLD: begin
                if (r_cnt == c_hold_last) begin
                    w_state_nxt = S_RELEASE;
                    w_cnt_nxt   = '0;
                    w_ack_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_WAIT;
                w_cnt_nxt   = '0;
                w_rst_nxt   = '1;
                w_done_nxt  = 1'b0;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_RUN);
    end

    assign rst_o        = r_rst;
    assign sw_rst_ack_o = r_ack;
    assign all_done_o   = r_done;
    assign busy_o       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_reset_sequencer
// Purpose  : Self-checking bench for reset_sequencer. A timeline model
//            (release start edge, hold start edge) predicts every output on
//            every falling clock edge; directed sections pin the model with
//            hand-computed values, then a randomized phase exercises requests
//            and asynchronous reset pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

    localparam int NUM_OUT     = 4;
    localparam int SYNC_STAGES = 2;
    localparam int STAGE_DELAY = 8;
    localparam int HOLD_CYCLES = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               req = 1'b0;
    logic               ack;
    logic [NUM_OUT-1:0] rst;
    logic               done;
    logic               busy;

    logic               req2 = 1'b0;
    logic               ack2;
    logic [0:0]         rst2;
    logic               done2;
    logic               busy2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_OUT     (NUM_OUT),
        .SYNC_STAGES (SYNC_STAGES),
        .STAGE_DELAY (STAGE_DELAY),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sw_rst_req_i (req),
        .sw_rst_ack_o (ack),
        .rst_o        (rst),
        .all_done_o   (done),
        .busy_o       (busy)
    );

    reset_sequencer #(
        .NUM_OUT     (1),
        .SYNC_STAGES (3),
        .STAGE_DELAY (1),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) dut_min (
        .clk          (clk),
        .reset        (reset),
        .sw_rst_req_i (req2),
        .sw_rst_ack_o (ack2),
        .rst_o        (rst2),
        .all_done_o   (done2),
        .busy_o       (busy2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " rst_o"}, 32'(rst), 32'hF);
        chk({tag, " ack"},   32'(ack), 32'h0);
        chk({tag, " done"},  32'(done), 32'h0);
        chk({tag, " busy"},  32'(busy), 32'h1);
    endtask

    // Timeline model: m_n counts posedges since reset fell; release of bit i
    // happens (i+1)*STAGE_DELAY edges after m_rel_start; a hold started at
    // m_hold_start ends HOLD_CYCLES edges later with an ack.
    int m_n          = 0;
    int m_rel_start  = SYNC_STAGES;
    int m_hold_start = -1;
    bit m_ack        = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_n          = 0;
            m_rel_start  = SYNC_STAGES;
            m_hold_start = -1;
            m_ack        = 1'b0;
        end else begin
            m_n   = m_n + 1;
            m_ack = 1'b0;
            if (m_hold_start >= 0) begin
                if (m_n - m_hold_start == HOLD_CYCLES) begin
                    m_rel_start  = m_n;
                    m_hold_start = -1;
                    m_ack        = 1'b1;
                end
            end else if (m_n > m_rel_start + NUM_OUT * STAGE_DELAY && req) begin
                m_hold_start = m_n;
            end
        end
    end

    function automatic int released();
        int k;
        if (m_hold_start >= 0) return 0;
        if (m_n < m_rel_start) return 0;
        k = (m_n - m_rel_start) / STAGE_DELAY;
        return (k > NUM_OUT) ? NUM_OUT : k;
    endfunction

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        int                 k;
        logic [NUM_OUT-1:0] ones;
        logic [NUM_OUT-1:0] e;
        ones = '1;
        k    = released();
        e    = ones << k;
        chk("model rst_o",      32'(rst),  32'(e));
        chk("model all_done_o", 32'(done), 32'(k == NUM_OUT));
        chk("model busy_o",     32'(busy), 32'(k != NUM_OUT));
        chk("model ack",        32'(ack),  32'(m_ack));
    end

    initial begin
        reset = 1'b1;
        req   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Power-on sequence; the minimal instance releases at edge 4.
        step(3);
        chk("min rst@3",  32'(rst2),  32'h1);
        chk("min done@3", 32'(done2), 32'h0);
        step(1);
        chk("min rst@4",  32'(rst2),  32'h0);
        chk("min done@4", 32'(done2), 32'h1);
        chk("min busy@4", 32'(busy2), 32'h0);
        step(5);
        chk("rst@9",  32'(rst), 32'hF);
        step(1);
        chk("rst@10", 32'(rst), 32'hE);
        step(7);
        chk("rst@17", 32'(rst), 32'hE);
        step(1);
        chk("rst@18", 32'(rst), 32'hC);
        step(8);
        chk("rst@26", 32'(rst), 32'h8);
        step(7);
        chk("done@33", 32'(done), 32'h0);
        chk("busy@33", 32'(busy), 32'h1);
        step(1);
        chk("rst@34",  32'(rst),  32'h0);
        chk("done@34", 32'(done), 32'h1);
        chk("busy@34", 32'(busy), 32'h0);

        // Software reset from RUN; request edge E is the next posedge.
        req = 1'b1;
        step(1);
        chk("sw rst@E",  32'(rst),  32'hF);
        chk("sw done@E", 32'(done), 32'h0);
        chk("sw ack@E",  32'(ack),  32'h0);
        step(3);
        chk("sw ack@E+3", 32'(ack), 32'h0);
        step(1);
        chk("sw ack@E+4", 32'(ack), 32'h1);
        req = 1'b0;
        step(1);
        chk("sw ack@E+5", 32'(ack), 32'h0);
        step(7);
        chk("sw rst@E+12", 32'(rst), 32'hE);
        step(23);
        chk("sw rst@E+35", 32'(rst), 32'h8);
        step(1);
        chk("sw rst@E+36",  32'(rst),  32'h0);
        chk("sw done@E+36", 32'(done), 32'h1);
        step(3);
        chk("sw no repeat", 32'(rst), 32'h0);

        // Short async reset pulse with a request held through RELEASE.
        req = 1'b1;
        #2 reset = 1'b1;
        #1 chk_reset_values("pulse");
        #2 reset = 1'b0;
        step(34);
        chk("held rst@34",  32'(rst),  32'h0);
        chk("held done@34", 32'(done), 32'h1);
        step(1);
        chk("held rst@35", 32'(rst), 32'hF);
        chk("held ack@35", 32'(ack), 32'h0);
        step(4);
        chk("held ack@39", 32'(ack), 32'h1);
        req = 1'b0;

        // Reset in the middle of RELEASE.
        step(15);
        chk("midrel rst", 32'(rst), 32'hE);
        #2 reset = 1'b1;
        #1 chk_reset_values("midrel");
        #2 reset = 1'b0;

        // Reset in the middle of SW_HOLD.
        step(34);
        chk("prehold rst", 32'(rst), 32'h0);
        req = 1'b1;
        step(2);
        chk("hold rst", 32'(rst), 32'hF);
        #2 reset = 1'b1;
        #1 chk_reset_values("midhold");
        #2 reset = 1'b0;
        req = 1'b0;
        step(40);

        // Randomized requests and reset pulses, checked by the model.
        repeat (4000) begin
            @(negedge clk);
            if (ack && $urandom_range(0, 7) != 0) begin
                req = 1'b0;
            end else if (!req && $urandom_range(0, 15) == 0) begin
                req = 1'b1;
            end else if (req && $urandom_range(0, 63) == 0) begin
                req = 1'b0;
            end
            if ($urandom_range(0, 299) == 0) begin
                #1 reset = 1'b1;
                #1 chk_reset_values("rand pulse");
                #2 reset = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
